pdm_modulator: RTL

- PDM transmitter: the mirror of the microphone-side CIC receiver chain.
- Accepts signed 16-bit PCM samples over a valid/ready handshake and holds each sample for a programmable number of PDM clocks (zero-order-hold interpolation).
- Converts samples to a 1-bit PDM stream with a first-order sigma-delta modulator.
- Generates its own PDM bit clock with the same divider scheme as the receiver. Used as a loopback/test source for the CIC path and to drive PDM actuators.

---
 rtl/pdm_pkg.sv | 16 +
 rtl/pdm_clk_gen.sv | 39 +++
 rtl/pdm_modulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM transmitter and its clock generator.
package pdm_pkg;
    localparam int SAMPLE_W = 16;
    localparam int UNDERRUN_W = 16;
    localparam int DIV_W = 32;
    localparam int OSR_W = 8;
    localparam logic CHANNEL_RIGHT = 1'b1;

    // What happens to the current sample at a hold-counter wrap.
    typedef enum logic [1:0] {
        ADV_NONE,
        ADV_POP,
        ADV_BYPASS,
        ADV_UNDERRUN
    } adv_e;
endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock divider: period (clk_div+1)*2 clk cycles, with rise/fall strobes.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int DIV_W = pdm_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    output logic             pdm_clk,
    output logic             rise_ev,
    output logic             fall_ev
);
    logic [DIV_W-1:0] counter;
    logic             tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            tc      <= 1'b1;
            pdm_clk <= 1'b1;
        end else begin
            if (counter == clk_div) begin
                counter <= '0;
                tc      <= 1'b1;
            end else begin
                counter <= counter + DIV_W'(1);
                tc      <= 1'b0;
            end
            if (tc) begin
                pdm_clk <= ~pdm_clk;
            end
        end
    end

    // Strobes mark the cycle in which pdm_clk is about to change.
    assign rise_ev = tc && !pdm_clk;
    assign fall_ev = tc && pdm_clk;
endmodule

// File: rtl/pdm_modulator.sv
// PCM-to-PDM transmitter: two-deep sample buffer, zero-order hold, first-order sigma-delta.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int SAMPLE_W = pdm_pkg::SAMPLE_W,
    parameter int UNDERRUN_W = pdm_pkg::UNDERRUN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic [OSR_W-1:0]      osr,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  pdm_clk,
    output logic                  pdm_data,
    output logic                  channel,
    output logic                  underrun,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);
    localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                rise_ev;
    logic                fall_ev;
    logic                unused_fall_ev;
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] nxt;
    logic                next_full;
    logic                primed;
    logic [OSR_W-1:0]    hold_cnt;

    logic                accept;
    logic                at_wrap;
    adv_e                adv;
    logic [SAMPLE_W-1:0] u;
    logic [SAMPLE_W:0]   sum;

    pdm_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .clk_div (clk_div),
        .pdm_clk (pdm_clk),
        .rise_ev (rise_ev),
        .fall_ev (fall_ev)
    );

    assign unused_fall_ev = fall_ev;

    always_comb begin
        accept  = sample_valid && !next_full;
        at_wrap = rise_ev && (hold_cnt == osr);
        adv     = ADV_NONE;
        if (at_wrap) begin
            if (next_full) begin
                adv = ADV_POP;
            end else if (accept) begin
                adv = ADV_BYPASS;
            end else if (primed) begin
                adv = ADV_UNDERRUN;
            end
        end
        // Adding half-scale to a two's-complement value is an MSB flip.
        u   = cur ^ MIDSCALE;
        sum = {1'b0, acc} + {1'b0, u};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cur          <= '0;
            nxt          <= '0;
            next_full    <= 1'b0;
            primed       <= 1'b0;
            hold_cnt     <= '0;
            pdm_data     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= (adv == ADV_UNDERRUN);
            if (rise_ev) begin
                acc      <= sum[SAMPLE_W-1:0];
                pdm_data <= sum[SAMPLE_W];
                hold_cnt <= at_wrap ? '0 : hold_cnt + OSR_W'(1);
            end
            if (accept) begin
                primed <= 1'b1;
            end
            case (adv)
                ADV_POP: begin
                    cur       <= nxt;
                    next_full <= 1'b0;
                end
                ADV_BYPASS: begin
                    cur <= sample_in;
                end
                ADV_UNDERRUN: begin
                    if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        nxt       <= sample_in;
                        next_full <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign sample_ready = !next_full;
    assign channel      = CHANNEL_RIGHT;
endmodule
